// File: rtl/fpnew_pipe_skid_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fpnew_pipe_skid_chain                                         |
// | Purpose  : Elastic valid/ready pipeline chain with an optional input     |
// |            skid buffer, tag-selective kill, global flush and occupancy.  |
// | Ports    : clk_i/rst_i          clock, async active-high reset          |
// |            in_*                 upstream payload, tag, valid/ready      |
// |            flush_i              drop every stored entry at next edge    |
// |            kill_i/kill_tag_i/   drop stored entries whose masked tag    |
// |            kill_mask_i          equals kill_tag_i                        |
// |            out_*                downstream payload, tag, valid/ready    |
// |            occupancy_o/busy_o   number of stored entries / non-empty    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fpnew_pipe_skid_chain #(
  parameter  int unsigned DataWidth   = 64,
  parameter  int unsigned TagWidth    = 4,
  parameter  int unsigned NumPipeRegs = 2,
  parameter  bit          CutReady    = 1'b1,
  localparam int unsigned CntWidth    = $clog2(NumPipeRegs + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic [TagWidth-1:0]  in_tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  input  logic                 kill_i,
  input  logic [TagWidth-1:0]  kill_tag_i,
  input  logic [TagWidth-1:0]  kill_mask_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [TagWidth-1:0]  out_tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CntWidth-1:0]  occupancy_o,
  output logic                 busy_o
);

  // Kill match on the tag an element will hold after the edge.
  function automatic logic kill_hit(input logic                kill,
                                    input logic [TagWidth-1:0] tag,
                                    input logic [TagWidth-1:0] ktag,
                                    input logic [TagWidth-1:0] kmask);
    return kill & (((tag ^ ktag) & kmask) == '0);
  endfunction

  // Stage 0: the entry offered to stage 1 (skid content first, else input).
  logic                 s0_valid;
  logic [DataWidth-1:0] s0_data;
  logic [TagWidth-1:0]  s0_tag;
  logic                 s0_ready;

  logic [CntWidth-1:0]  skid_cnt_d;
  logic [CntWidth-1:0]  pipe_cnt_d;
  logic [CntWidth-1:0]  occupancy_d;
  logic [CntWidth-1:0]  occupancy_q;

  // --------------------------------------------------------------------------
  // Input skid buffer
  // --------------------------------------------------------------------------
  generate
    if (CutReady) begin : g_skid
      logic                 s_valid_q, s_valid_d;
      logic [DataWidth-1:0] s_data_q,  s_data_d;
      logic [TagWidth-1:0]  s_tag_q,   s_tag_d;
      logic                 in_ready_q, in_ready_d;

      always_comb begin
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;
        if (s_valid_q) begin
          // Held entry drains as soon as stage 1 can take it.
          if (s0_ready) s_valid_d = 1'b0;
        end else if (in_valid_i && !s0_ready) begin
          // Accepted while the chain is blocked: park it here.
          s_valid_d = 1'b1;
          s_data_d  = in_data_i;
          s_tag_d   = in_tag_i;
        end
        if (kill_hit(kill_i, s_tag_d, kill_tag_i, kill_mask_i)) s_valid_d = 1'b0;
        if (flush_i) s_valid_d = 1'b0;
        // Registered copy keeps in_ready_o free of any combinational path.
        in_ready_d = ~s_valid_d;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s_valid_q  <= 1'b0;
          s_data_q   <= '0;
          s_tag_q    <= '0;
          in_ready_q <= 1'b1;
        end else begin
          s_valid_q  <= s_valid_d;
          s_data_q   <= s_data_d;
          s_tag_q    <= s_tag_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign s0_valid   = s_valid_q | in_valid_i;
      assign s0_data    = s_valid_q ? s_data_q : in_data_i;
      assign s0_tag     = s_valid_q ? s_tag_q  : in_tag_i;
      assign in_ready_o = in_ready_q;
      assign skid_cnt_d = CntWidth'(s_valid_d);
    end else begin : g_noskid
      assign s0_valid   = in_valid_i;
      assign s0_data    = in_data_i;
      assign s0_tag     = in_tag_i;
      assign in_ready_o = s0_ready;
      assign skid_cnt_d = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Register stages 1..NumPipeRegs (array index k holds stage k+1)
  // --------------------------------------------------------------------------
  generate
    if (NumPipeRegs > 0) begin : g_pipe
      logic [NumPipeRegs-1:0] valid_q, valid_d;
      logic [DataWidth-1:0]   data_q [NumPipeRegs];
      logic [DataWidth-1:0]   data_d [NumPipeRegs];
      logic [TagWidth-1:0]    tag_q  [NumPipeRegs];
      logic [TagWidth-1:0]    tag_d  [NumPipeRegs];

      // Unified view of stages 0..NumPipeRegs.
      logic [NumPipeRegs:0]   all_valid;
      logic [DataWidth-1:0]   all_data [NumPipeRegs+1];
      logic [TagWidth-1:0]    all_tag  [NumPipeRegs+1];
      logic [NumPipeRegs:0]   ready;

      always_comb begin
        all_valid   = {valid_q, s0_valid};
        all_data[0] = s0_data;
        all_tag[0]  = s0_tag;
        for (int k = 1; k <= int'(NumPipeRegs); k++) begin
          all_data[k] = data_q[k-1];
          all_tag[k]  = tag_q[k-1];
        end
      end

      // A stage may hand its entry on when the next one is empty or moving;
      // this lets bubbles collapse under a downstream stall.
      always_comb begin
        ready[NumPipeRegs] = out_ready_i;
        for (int k = int'(NumPipeRegs) - 1; k >= 0; k--) begin
          ready[k] = ready[k+1] | ~all_valid[k+1];
        end
      end

      always_comb begin
        pipe_cnt_d = '0;
        for (int k = 0; k < int'(NumPipeRegs); k++) begin
          valid_d[k] = valid_q[k];
          data_d[k]  = data_q[k];
          tag_d[k]   = tag_q[k];
          if (ready[k]) begin
            valid_d[k] = all_valid[k];
            if (all_valid[k]) begin
              data_d[k] = all_data[k];
              tag_d[k]  = all_tag[k];
            end
          end
          if (kill_hit(kill_i, tag_d[k], kill_tag_i, kill_mask_i)) valid_d[k] = 1'b0;
          if (flush_i) valid_d[k] = 1'b0;
          pipe_cnt_d = pipe_cnt_d + CntWidth'(valid_d[k]);
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_q <= '0;
          for (int k = 0; k < int'(NumPipeRegs); k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
          end
        end else begin
          valid_q <= valid_d;
          for (int k = 0; k < int'(NumPipeRegs); k++) begin
            data_q[k] <= data_d[k];
            tag_q[k]  <= tag_d[k];
          end
        end
      end

      assign s0_ready    = ready[0];
      assign out_valid_o = all_valid[NumPipeRegs];
      assign out_data_o  = all_data[NumPipeRegs];
      assign out_tag_o   = all_tag[NumPipeRegs];
    end else begin : g_nopipe
      assign s0_ready    = out_ready_i;
      assign out_valid_o = s0_valid;
      assign out_data_o  = s0_data;
      assign out_tag_o   = s0_tag;
      assign pipe_cnt_d  = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Occupancy: registered popcount of the next-state valid bits, so it always
  // matches the valid flops it describes.
  // --------------------------------------------------------------------------
  assign occupancy_d = pipe_cnt_d + skid_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) occupancy_q <= '0;
    else       occupancy_q <= occupancy_d;
  end

  assign occupancy_o = occupancy_q;
  assign busy_o      = (occupancy_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpnew_pipe_skid_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fpnew_pipe_skid_chain                                      |
// | Purpose  : Self-checking bench for fpnew_pipe_skid_chain. Main instance  |
// |            uses NumPipeRegs=2/CutReady=1; a second instance uses the     |
// |            pass-through configuration NumPipeRegs=0/CutReady=0.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fpnew_pipe_skid_chain;

  localparam int DW = 64;
  localparam int TW = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  // Main instance signals
  logic [DW-1:0] in_data   = '0;
  logic [TW-1:0] in_tag    = '0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic          flush     = 1'b0;
  logic          kill      = 1'b0;
  logic [TW-1:0] kill_tag  = '0;
  logic [TW-1:0] kill_mask = '0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
  logic          busy;

  // Pass-through instance signals
  logic [DW-1:0] p_in_data   = '0;
  logic [TW-1:0] p_in_tag    = '0;
  logic          p_in_valid  = 1'b0;
  logic          p_in_ready;
  logic          p_flush     = 1'b0;
  logic          p_kill      = 1'b0;
  logic [TW-1:0] p_kill_tag  = '0;
  logic [TW-1:0] p_kill_mask = '0;
  logic [DW-1:0] p_out_data;
  logic [TW-1:0] p_out_tag;
  logic          p_out_valid;
  logic          p_out_ready = 1'b0;
  logic [0:0]    p_occupancy;
  logic          p_busy;

  fpnew_pipe_skid_chain #(
    .DataWidth(DW), .TagWidth(TW), .NumPipeRegs(2), .CutReady(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(in_data), .in_tag_i(in_tag), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .kill_i(kill), .kill_tag_i(kill_tag), .kill_mask_i(kill_mask),
    .out_data_o(out_data), .out_tag_o(out_tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .occupancy_o(occupancy), .busy_o(busy)
  );

  fpnew_pipe_skid_chain #(
    .DataWidth(DW), .TagWidth(TW), .NumPipeRegs(0), .CutReady(1'b0)
  ) dut_p (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(p_in_data), .in_tag_i(p_in_tag), .in_valid_i(p_in_valid), .in_ready_o(p_in_ready),
    .flush_i(p_flush), .kill_i(p_kill), .kill_tag_i(p_kill_tag), .kill_mask_i(p_kill_mask),
    .out_data_o(p_out_data), .out_tag_o(p_out_tag), .out_valid_o(p_out_valid), .out_ready_i(p_out_ready),
    .occupancy_o(p_occupancy), .busy_o(p_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } item_t;

  // Stimulus is applied on the falling edge and outputs are sampled 1ns later.
  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    flush = 1'b0; kill = 1'b0; kill_tag = '0; kill_mask = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Push one entry per cycle with out_ready low (tags from the list).
  task automatic fill(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                      input logic [TW-1:0] t2, input int n);
    logic [TW-1:0] tags [3];
    tags[0] = t0; tags[1] = t1; tags[2] = t2;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_tag = tags[i]; in_data = DW'(64'hA000 + i);
      @(negedge clk_i);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_cmp++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    @(negedge clk_i);
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d [8];
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        exp_d[c] = {$urandom, $urandom};
        in_valid = 1'b1; in_data = exp_d[c]; in_tag = TW'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[c-2] || out_tag !== TW'(c-2)) begin
          n_err++; $display("FAIL stream_out c=%0d got v=%b d=%h t=%0d exp v=1 d=%h t=%0d",
                            c, out_valid, out_data, out_tag, exp_d[c-2], c-2);
        end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency c=%0d got=%b exp=0", c, out_valid); end
      end
      if (c >= 2 && c <= 8) begin
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL stream_occupancy c=%0d got=%0d exp=2", c, occupancy); end
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] base;
    int accepts;
    int got;
    base = {$urandom, $urandom};
    accepts = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = base + DW'(accepts); in_tag = TW'(accepts);
      #1;
      if (c >= 3) begin
        n_cmp++; if (in_ready !== 1'b0 || occupancy !== 2'd3) begin
          n_err++; $display("FAIL full_hold c=%0d got rdy=%b occ=%0d exp rdy=0 occ=3", c, in_ready, occupancy);
        end
      end
      if (in_ready) accepts++;
      @(negedge clk_i);
    end
    n_cmp++; if (accepts != 3) begin n_err++; $display("FAIL full_accepts got=%0d exp=3", accepts); end
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        n_cmp++; if (out_data !== base + DW'(got) || out_tag !== TW'(got)) begin
          n_err++; $display("FAIL full_order idx=%0d got d=%h t=%0d exp d=%h t=%0d",
                            got, out_data, out_tag, base + DW'(got), got);
        end
        got++;
      end
      @(negedge clk_i);
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL full_drain_count got=%0d exp=3", got); end
  endtask

  task automatic test_kill_exact();
    int seen;
    do_reset();
    fill(4'd3, 4'd5, 4'd3, 3);
    kill = 1'b1; kill_tag = 4'd3; kill_mask = 4'hF;
    @(negedge clk_i);
    kill = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 2'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL kill_exact_occ got occ=%0d busy=%b exp occ=1 busy=1", occupancy, busy);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kill_exact_bubble got=%b exp=0", out_valid); end
    @(negedge clk_i);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        seen++;
        n_cmp++; if (out_tag !== 4'd5) begin n_err++; $display("FAIL kill_exact_tag got=%0d exp=5", out_tag); end
      end
      @(negedge clk_i);
    end
    n_cmp++; if (seen != 1) begin n_err++; $display("FAIL kill_exact_survivors got=%0d exp=1", seen); end
  endtask

  task automatic test_kill_mask();
    do_reset();
    fill(4'd2, 4'd1, 4'd3, 3);
    // Tag 2 leaves on this edge; 3 moves skid->stage1 and is dropped.
    out_ready = 1'b1; kill = 1'b1; kill_tag = 4'h2; kill_mask = 4'h2;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd2) begin
      n_err++; $display("FAIL kill_mask_deliver got v=%b t=%0d exp v=1 t=2", out_valid, out_tag);
    end
    @(negedge clk_i);
    kill = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_tag !== 4'd1) begin
      n_err++; $display("FAIL kill_mask_survivor got occ=%0d v=%b t=%0d exp occ=1 v=1 t=1", occupancy, out_valid, out_tag);
    end
    @(negedge clk_i);
    out_ready = 1'b1;
    @(negedge clk_i);
    #1;
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL kill_mask_empty got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
    end
    // Entry accepted on a kill edge with a matching tag (6) is dropped.
    in_valid = 1'b1; in_tag = 4'd6; in_data = 64'h6666; kill = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL kill_mask_accept got=%b exp=1", in_ready); end
    @(negedge clk_i);
    in_valid = 1'b0; kill = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL kill_mask_incoming got=%0d exp=0", occupancy); end
    @(negedge clk_i);
  endtask

  task automatic test_flush();
    int seen;
    do_reset();
    fill(4'd0, 4'd1, 4'd0, 2);
    flush = 1'b1; kill = 1'b1; kill_tag = 4'hF; kill_mask = 4'hF;
    in_valid = 1'b1; in_tag = 4'd9; in_data = 64'hDEAD_BEEF;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_handshake got rdy=%b v=%b exp rdy=1 v=1", in_ready, out_valid);
    end
    @(negedge clk_i);
    flush = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_clear got v=%b busy=%b occ=%0d rdy=%b exp 0 0 0 1", out_valid, busy, occupancy, in_ready);
    end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_ghost got=%0d outputs exp=0", seen); end
    @(negedge clk_i);
  endtask

  task automatic test_passthrough();
    for (int c = 0; c < 16; c++) begin
      p_in_data = {$urandom, $urandom}; p_in_tag = TW'($urandom_range(0, 15));
      p_in_valid = 1'($urandom_range(0, 1)); p_out_ready = 1'($urandom_range(0, 1));
      p_kill = 1'($urandom_range(0, 1)); p_kill_mask = '0; p_flush = (c == 7);
      #1;
      n_cmp++; if (p_out_data !== p_in_data || p_out_tag !== p_in_tag || p_out_valid !== p_in_valid) begin
        n_err++; $display("FAIL pass_out c=%0d got d=%h t=%0d v=%b exp d=%h t=%0d v=%b", c,
                          p_out_data, p_out_tag, p_out_valid, p_in_data, p_in_tag, p_in_valid);
      end
      n_cmp++; if (p_in_ready !== p_out_ready) begin
        n_err++; $display("FAIL pass_ready c=%0d got=%b exp=%b", c, p_in_ready, p_out_ready);
      end
      n_cmp++; if (p_occupancy !== 1'b0 || p_busy !== 1'b0) begin
        n_err++; $display("FAIL pass_occ c=%0d got occ=%0d busy=%b exp 0 0", c, p_occupancy, p_busy);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_tag = TW'(c); in_data = DW'(c + 100);
      @(negedge clk_i);
    end
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL reset_mid got v=%b rdy=%b occ=%0d exp 0 1 0", out_valid, in_ready, occupancy);
    end
    @(negedge clk_i);
    rst_i = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1; if (out_valid) seen++;
      @(negedge clk_i);
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL reset_mid_ghost got=%0d exp=0", seen); end
  endtask

  // Random traffic against an abstract queue model: the queue holds every
  // accepted entry that has not been delivered, killed or flushed.
  task automatic test_random();
    item_t mq[$];
    item_t keep[$];
    item_t it;
    int    bias;
    do_reset();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      bias      = ((c / 60) % 2 == 1) ? 1 : 3;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      in_tag    = TW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) < bias);
      kill      = ($urandom_range(0, 9) == 0);
      kill_tag  = TW'($urandom_range(0, 15));
      kill_mask = TW'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 49) == 0);
      #1;
      n_cmp++; if (occupancy !== 2'(mq.size())) begin
        n_err++; $display("FAIL rand_occupancy c=%0d got=%0d exp=%0d", c, occupancy, mq.size());
      end
      n_cmp++; if (busy !== (mq.size() != 0)) begin
        n_err++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, mq.size() != 0);
      end
      if (mq.size() == 3) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rand_full_ready c=%0d got=%b exp=0", c, in_ready); end
      end
      if (mq.size() == 0) begin
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_err++; $display("FAIL rand_empty c=%0d got rdy=%b v=%b exp rdy=1 v=0", c, in_ready, out_valid);
        end
      end
      if (out_valid === 1'b1 && mq.size() > 0) begin
        n_cmp++; if (out_data !== mq[0].data || out_tag !== mq[0].tag) begin
          n_err++; $display("FAIL rand_order c=%0d got d=%h t=%0d exp d=%h t=%0d", c, out_data, out_tag, mq[0].data, mq[0].tag);
        end
        if (out_ready) void'(mq.pop_front());
      end
      if (in_valid && in_ready === 1'b1) begin
        it.data = in_data; it.tag = in_tag;
        mq.push_back(it);
      end
      if (flush) begin
        mq.delete();
      end else if (kill) begin
        keep.delete();
        foreach (mq[i]) if (((mq[i].tag ^ kill_tag) & kill_mask) != 0) keep.push_back(mq[i]);
        mq = keep;
      end
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_i);
    test_reset();
    test_stream();
    test_full_stall();
    test_kill_exact();
    test_kill_mask();
    test_flush();
    test_passthrough();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
